// File: rtl/cpu_sram_axi_master.sv
// CPU SRAM-like port (32-bit, one outstanding access) to single-beat AXI3 master on a 64-bit bus.
// Optional response checking onto cpu_err: define CPU_SRAM_AXI_RESP_CHECK_EN.
module cpu_sram_axi_master #(
  parameter int         BUS_WIDTH  = 32,
  parameter int         DATA_WIDTH = 64,
  parameter int         CPU_WIDTH  = 32,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cpu_req,
  input  logic                    cpu_wr,
  input  logic [1:0]              cpu_size,
  input  logic [BUS_WIDTH-1:0]    cpu_addr,
  input  logic [CPU_WIDTH-1:0]    cpu_wdata,
  input  logic [CPU_WIDTH/8-1:0]  cpu_wstrb,
  output logic                    cpu_addr_ok,
  output logic                    cpu_data_ok,
  output logic [CPU_WIDTH-1:0]    cpu_rdata,
  output logic                    cpu_err,
  output logic [BUS_WIDTH-1:0]    m_araddr,
  output logic [2:0]              m_arsize,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [3:0]              m_arlen,
  output logic [1:0]              m_arburst,
  output logic [3:0]              m_arcache,
  output logic [1:0]              m_arlock,
  output logic [2:0]              m_arprot,
  output logic [3:0]              m_arid,
  output logic [BUS_WIDTH-1:0]    m_awaddr,
  output logic [2:0]              m_awsize,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [3:0]              m_awlen,
  output logic [1:0]              m_awburst,
  output logic [3:0]              m_awcache,
  output logic [1:0]              m_awlock,
  output logic [2:0]              m_awprot,
  output logic [3:0]              m_awid,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic [3:0]              m_wid,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic [3:0]              m_rid,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [1:0]              m_bresp,
  input  logic [3:0]              m_bid,
  input  logic                    m_bvalid,
  output logic                    m_bready
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE} state_e;

  state_e                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]             size_q, size_d;
  logic [CPU_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CPU_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                   aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [CPU_WIDTH-1:0]   rdata_q, rdata_d;
  logic                   aw_fire, w_fire, r_fire, b_fire;

  assign aw_fire = m_awvalid && m_awready;
  assign w_fire  = m_wvalid && m_wready;
  assign r_fire  = m_rvalid && m_rready;
  assign b_fire  = m_bvalid && m_bready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req) state_d = cpu_wr ? WR_AW_W : RD_AR;
      RD_AR:   if (m_arready) state_d = RD_R;
      RD_R:    if (m_rvalid) state_d = DONE;
      WR_AW_W: if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = WR_B;
      WR_B:    if (m_bvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_addr_ok = cpu_req && (state_q == IDLE);
    cpu_data_ok = (state_q == DONE);
    m_arvalid   = (state_q == RD_AR);
    m_rready    = (state_q == RD_R);
    m_awvalid   = (state_q == WR_AW_W) && !aw_done_q;
    m_wvalid    = (state_q == WR_AW_W) && !w_done_q;
    m_bready    = (state_q == WR_B);
  end

  // Request fields are captured once at acceptance; the CPU may change its inputs afterwards.
  always_comb begin
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    if (cpu_addr_ok) begin
      addr_d  = cpu_addr;
      size_d  = cpu_size;
      wdata_d = cpu_wdata;
      wstrb_d = cpu_wstrb;
    end
    if (r_fire) rdata_d = addr_q[2] ? m_rdata[DATA_WIDTH-1:CPU_WIDTH] : m_rdata[CPU_WIDTH-1:0];
    aw_done_d = (state_q == WR_AW_W) && (state_d == WR_AW_W) && (aw_done_q || aw_fire);
    w_done_d  = (state_q == WR_AW_W) && (state_d == WR_AW_W) && (w_done_q || w_fire);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign m_araddr  = addr_q;
  assign m_arsize  = {1'b0, size_q};
  assign m_awaddr  = addr_q;
  assign m_awsize  = {1'b0, size_q};
  assign m_wdata   = {wdata_q, wdata_q};
  assign m_wstrb   = addr_q[2] ? {wstrb_q, {(CPU_WIDTH/8){1'b0}}} : {{(CPU_WIDTH/8){1'b0}}, wstrb_q};
  assign m_wlast   = 1'b1;
  assign m_wid     = AXI_ID;
  assign {m_arlen, m_arburst, m_arcache, m_arlock, m_arprot, m_arid} = {4'd0, 2'b01, 4'd0, 2'd0, 3'd0, AXI_ID};
  assign {m_awlen, m_awburst, m_awcache, m_awlock, m_awprot, m_awid} = {4'd0, 2'b01, 4'd0, 2'd0, 3'd0, AXI_ID};

`ifdef CPU_SRAM_AXI_RESP_CHECK_EN
  logic err_q, err_d;
  always_comb begin
    err_d = err_q;
    if (r_fire) err_d = m_rresp[1];
    if (b_fire) err_d = m_bresp[1];
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign cpu_err = err_q;
  logic unused_ok;
  assign unused_ok = ^{m_rid, m_rlast, m_bid, m_rresp[0], m_bresp[0]};
`else
  assign cpu_err = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{m_rid, m_rlast, m_bid, m_rresp, m_bresp, b_fire};
`endif

endmodule

// File: tb/tb_cpu_sram_axi_master.sv
// Directed bench for cpu_sram_axi_master: configurable-wait AXI slave, scoreboard of expected completions.
module tb_cpu_sram_axi_master;
  logic        aclk, aresetn;
  logic        cpu_req, cpu_wr, cpu_addr_ok, cpu_data_ok, cpu_err;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] m_araddr, m_awaddr;
  logic [2:0]  m_arsize, m_awsize, m_arprot, m_awprot;
  logic        m_arvalid, m_arready, m_awvalid, m_awready;
  logic [3:0]  m_arlen, m_awlen, m_arcache, m_awcache, m_arid, m_awid, m_wid, m_rid, m_bid;
  logic [1:0]  m_arburst, m_awburst, m_arlock, m_awlock, m_rresp, m_bresp;
  logic [63:0] m_wdata, m_rdata;
  logic [7:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready, m_rlast, m_rvalid, m_rready, m_bvalid, m_bready;

  cpu_sram_axi_master dut (
    .aclk(aclk), .aresetn(aresetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_addr_ok(cpu_addr_ok),
    .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_arlen(m_arlen), .m_arburst(m_arburst), .m_arcache(m_arcache), .m_arlock(m_arlock),
    .m_arprot(m_arprot), .m_arid(m_arid),
    .m_awaddr(m_awaddr), .m_awsize(m_awsize), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awlen(m_awlen), .m_awburst(m_awburst), .m_awcache(m_awcache), .m_awlock(m_awlock),
    .m_awprot(m_awprot), .m_awid(m_awid),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wid(m_wid),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rid(m_rid), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_bresp(m_bresp), .m_bid(m_bid), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int errors = 0, checks = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: each wait is the number of cycles the valid is held before ready/valid answers.
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [63:0] slv_rdata = '0;
  logic [1:0]  slv_rresp = 2'b00, slv_bresp = 2'b00;
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  bit          r_pend, aw_seen, w_seen, b_pend;
  int          w_beats = 0;

  assign m_arready = m_arvalid && (ar_cnt >= ar_wait);
  assign m_rvalid  = r_pend && (r_cnt >= r_wait);
  assign m_awready = m_awvalid && (aw_cnt >= aw_wait);
  assign m_wready  = m_wvalid && (w_cnt >= w_wait);
  assign m_bvalid  = b_pend && (b_cnt >= b_wait);
  assign m_rdata   = slv_rdata;
  assign m_rresp   = m_rvalid ? slv_rresp : 2'b00;
  assign m_bresp   = m_bvalid ? slv_bresp : 2'b00;
  assign m_rid     = 4'd0;
  assign m_rlast   = 1'b1;
  assign m_bid     = 4'd0;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      r_pend <= 0; aw_seen <= 0; w_seen <= 0; b_pend <= 0;
    end else begin
      if (m_arvalid) ar_cnt <= m_arready ? 0 : ar_cnt + 1;
      if (m_arvalid && m_arready) begin
        r_pend <= 1; r_cnt <= 0;
      end else if (r_pend) begin
        if (m_rvalid && m_rready) r_pend <= 0;
        else r_cnt <= r_cnt + 1;
      end
      if (m_awvalid) aw_cnt <= m_awready ? 0 : aw_cnt + 1;
      if (m_wvalid)  w_cnt  <= m_wready  ? 0 : w_cnt + 1;
      if (m_awvalid && m_awready) aw_seen <= 1;
      if (m_wvalid && m_wready) begin
        w_seen  <= 1;
        w_beats <= w_beats + 1;
      end
      if (!b_pend && aw_seen && w_seen) begin
        b_pend <= 1; b_cnt <= 0; aw_seen <= 0; w_seen <= 0;
      end else if (b_pend) begin
        if (m_bvalid && m_bready) b_pend <= 0;
        else b_cnt <= b_cnt + 1;
      end
    end
  end

  typedef struct {
    bit          wr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int done_cnt = 0, done_cyc = 0, b_cyc = 0, acc_cyc = 0;

  always @(negedge aclk) begin
    if (m_bvalid && m_bready) b_cyc = cyc;
    if (cpu_data_ok) begin
      exp_t e;
      done_cnt++;
      done_cyc = cyc;
      if (sb.size() == 0) check("sb_unexpected_data_ok", 1, 0);
      else begin
        e = sb.pop_front();
        if (!e.wr) check("cpu_rdata", cpu_rdata, e.rdata);
        check("cpu_err", cpu_err, e.err);
      end
    end
  end

  function automatic logic exp_err(input logic [1:0] resp);
`ifdef CPU_SRAM_AXI_RESP_CHECK_EN
    return resp[1];
`else
    return 1'b0 & resp[1];
`endif
  endfunction

  function automatic exp_t mk_exp(input bit wr, input logic [31:0] addr, input logic [63:0] rd,
                                  input logic [1:0] resp);
    exp_t e;
    e.wr    = wr;
    e.rdata = wr ? 32'h0 : (addr[2] ? rd[63:32] : rd[31:0]);
    e.err   = exp_err(resp);
    return e;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic issue(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic [63:0] rd, input logic [1:0] resp);
    sb.push_back(mk_exp(wr, addr, rd, resp));
    cpu_req = 1; cpu_wr = wr; cpu_size = size; cpu_addr = addr;
    cpu_wdata = wdata; cpu_wstrb = wstrb;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (cpu_addr_ok) break;
    end
    if (!cpu_addr_ok) check("accept_timeout", 0, 1);
    acc_cyc = cyc;
    @(posedge aclk); #1;
    cpu_req = 0;
  endtask

  task automatic wait_done(input int start);
    for (int i = 0; i < 60; i++) begin
      @(posedge aclk);
      if (done_cnt > start) break;
    end
    check("done_timeout", done_cnt > start, 1);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, wb0, aw_cycles, busy, acc2;
    aresetn = 0; cpu_req = 0; cpu_wr = 0; cpu_size = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_valids", {m_arvalid, m_awvalid, m_wvalid}, 3'b000);
    check("rst_readys", {m_rready, m_bready}, 2'b00);
    check("rst_cpu", {cpu_data_ok, cpu_err, cpu_addr_ok}, 3'b000);
    check("rst_rdata", cpu_rdata, 32'h0);
    aresetn = 1;
    @(posedge aclk); #1;

    // 1: zero-wait read, upper word
    slv_rdata = 64'h1111_2222_3333_4444;
    n0 = done_cnt;
    issue(0, 2'd2, 32'h1000_0004, 32'h0, 4'h0, slv_rdata, 2'b00);
    check("t1_arvalid", m_arvalid, 1);
    check("t1_araddr", m_araddr, 32'h1000_0004);
    check("t1_arsize", m_arsize, 3'd2);
    check("t1_arlen_burst_id", {m_arlen, m_arburst, m_arid}, {4'd0, 2'b01, 4'd0});
    check("t1_ar_consts", {m_arcache, m_arlock, m_arprot}, 9'd0);
    wait_done(n0);
    check("t1_latency", done_cyc - acc_cyc, 3);

    // 2: zero-wait full-word write, lower half
    n0 = done_cnt;
    issue(1, 2'd2, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 64'h0, 2'b00);
    check("t2_valids", {m_awvalid, m_wvalid}, 2'b11);
    check("t2_wdata", m_wdata, 64'hDEADBEEF_DEADBEEF);
    check("t2_wstrb", m_wstrb, 8'h0F);
    check("t2_wlast", m_wlast, 1);
    check("t2_awaddr_size", {m_awaddr, m_awsize}, {32'h0, 3'd2});
    check("t2_aw_consts", {m_awlen, m_awburst, m_awcache, m_awlock, m_awprot, m_awid, m_wid},
          {4'd0, 2'b01, 4'd0, 2'd0, 3'd0, 4'd0, 4'd0});
    wait_done(n0);
    check("t2_data_ok_after_b", done_cyc - b_cyc, 1);

    // 3: W accepted in cycle 1, AW in cycle 4; half-word to upper lane
    aw_wait = 3; w_wait = 0;
    wb0 = w_beats;
    n0 = done_cnt;
    issue(1, 2'd1, 32'h0000_0014, 32'h0000_CAFE, 4'h3, 64'h0, 2'b00);
    check("t3_wstrb_hi", m_wstrb, 8'h30);
    check("t3_c1_valids", {m_awvalid, m_wvalid}, 2'b11);
    aw_cycles = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk); #1;
      if (!m_awvalid) break;
      aw_cycles++;
      check("t3_wvalid_dropped", m_wvalid, 0);
      check("t3_bready_early", m_bready, 0);
    end
    check("t3_aw_cycles", aw_cycles, 4);
    check("t3_bready_after_aw", m_bready, 1);
    wait_done(n0);
    check("t3_w_beats", w_beats - wb0, 1);
    aw_wait = 0;

    // 4: stalled read with the next request held high while busy
    ar_wait = 5; r_wait = 3;
    slv_rdata = 64'h5555_6666_7777_8888;
    n0 = done_cnt;
    issue(0, 2'd2, 32'h0000_0100, 32'h0, 4'h0, slv_rdata, 2'b00);
    sb.push_back(mk_exp(0, 32'h0000_0204, slv_rdata, 2'b00));
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h0000_0204;
    busy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge aclk);
      if (cpu_addr_ok) break;
      busy++;
    end
    acc2 = cyc;
    check("t4_busy_cycles", busy, 11);
    check("t4_accept_after_done", acc2, done_cyc + 1);
    @(posedge aclk); #1;
    cpu_req = 0;
    wait_done(n0 + 1);
    ar_wait = 0; r_wait = 0;

    // 5: asynchronous reset while waiting in RD_R
    r_wait = 10;
    slv_rdata = 64'h9999_0000_9999_0000;
    issue(0, 2'd2, 32'h0000_0040, 32'h0, 4'h0, slv_rdata, 2'b00);
    for (int i = 0; i < 10; i++) begin
      if (m_rready) break;
      @(posedge aclk); #1;
    end
    check("t5_in_rd_r", m_rready, 1);
    #2;
    aresetn = 0;
    #1;
    check("t5_abort_handshakes", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, 5'b0);
    check("t5_abort_data_ok", cpu_data_ok, 0);
    check("t5_abort_rdata", cpu_rdata, 32'h0);
    sb.delete();
    repeat (2) @(negedge aclk);
    aresetn = 1;
    r_wait = 0;
    slv_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(posedge aclk); #1;
    n0 = done_cnt;
    issue(0, 2'd2, 32'h0000_0008, 32'h0, 4'h0, slv_rdata, 2'b00);
    wait_done(n0);
    check("t5_done_count", done_cnt - n0, 1);

    // 6: error responses; read data still delivered
    slv_rresp = 2'b10;
    slv_rdata = 64'h0BAD_0BAD_1234_5678;
    n0 = done_cnt;
    issue(0, 2'd2, 32'h0000_000C, 32'h0, 4'h0, slv_rdata, 2'b10);
    wait_done(n0);
    slv_rresp = 2'b00;
    slv_bresp = 2'b11;
    n0 = done_cnt;
    issue(1, 2'd0, 32'h0000_0003, 32'h0000_00A5, 4'h8, 64'h0, 2'b11);
    wait_done(n0);
    slv_bresp = 2'b00;
    n0 = done_cnt;
    issue(0, 2'd2, 32'h0000_0010, 32'h0, 4'h0, slv_rdata, 2'b00);
    wait_done(n0);

    repeat (3) @(posedge aclk);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
